// File: rtl/submatrix_pkg.sv
// Shared types and sizing helpers for the submatrix downsampler and its serial popcount.
package submatrix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int GROUP_W_DEFAULT = 16;

  function automatic int count_w(input int group_w);
    return $clog2(group_w + 1);
  endfunction

endpackage

// File: rtl/submatrix_downsampler_serial_popcount.sv
// Serial popcount: shift register, running count and bit index for one submatrix group.
module serial_popcount
  import submatrix_pkg::*;
#(
  parameter int GROUP_W = GROUP_W_DEFAULT,
  parameter int COUNT_W = count_w(GROUP_W)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               shift_i,
  input  logic [GROUP_W-1:0] data_i,
  output logic               busy_o,
  output logic               last_o,
  output logic [COUNT_W-1:0] count_o
);

  localparam int IDX_W = (GROUP_W > 1) ? $clog2(GROUP_W) : 1;

  logic [GROUP_W-1:0] shreg_q, shreg_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               last_s;

  assign last_s  = busy_q && (idx_q == IDX_W'(GROUP_W - 1));
  assign busy_o  = busy_q;
  assign last_o  = last_s;
  // Count including the bit consumed by a shift in this cycle, so the owner
  // can register a result on the same edge as the final shift.
  assign count_o = count_q + COUNT_W'(shreg_q[0]);

  always_comb begin
    shreg_d = shreg_q;
    count_d = count_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    if (load_i) begin
      shreg_d = data_i;
      count_d = '0;
      idx_d   = '0;
      busy_d  = 1'b1;
    end else if (shift_i && busy_q) begin
      shreg_d = shreg_q >> 1;
      count_d = count_q + COUNT_W'(shreg_q[0]);
      idx_d   = idx_q + IDX_W'(1);
      busy_d  = !last_s;
    end else begin
      busy_d  = busy_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shreg_q <= '0;
      count_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/submatrix_downsampler.sv
// Thresholds the popcount of each 4x4 submatrix into one pixel written to a sequential RAM address.
// Optional sticky handshake-violation flag under SUBMATRIX_DOWNSAMPLER_PROTOCOL_ERR_EN.
module submatrix_downsampler
  import submatrix_pkg::*;
#(
  parameter int GROUP_W    = GROUP_W_DEFAULT,
  parameter int NUM_GROUPS = 4096,
  parameter int OUT_ADDR_W = 12,
  parameter int THRESHOLD  = 8
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  loaded,
  input  logic [GROUP_W-1:0]    submatrixElements,
  output logic                  readyToBeLoaded,
  output logic                  wrEn,
  output logic [OUT_ADDR_W-1:0] wrAddress,
  output logic                  wrData,
`ifdef SUBMATRIX_DOWNSAMPLER_PROTOCOL_ERR_EN
  output logic                  protocolError,
`endif
  output logic                  done
);

  localparam int                  COUNT_W     = count_w(GROUP_W);
  localparam logic [COUNT_W-1:0]  THR_C       = COUNT_W'(THRESHOLD);
  localparam logic [OUT_ADDR_W-1:0] LAST_ADDR_C = OUT_ADDR_W'(NUM_GROUPS - 1);

  state_e                state_q, state_d;
  logic [OUT_ADDR_W-1:0] addr_q, addr_d;
  logic                  ready_q, ready_d;
  logic                  wr_en_q, wr_en_d;
  logic                  wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  pc_load_s, pc_shift_s, pc_busy_s, pc_last_s;
  logic [COUNT_W-1:0]    pc_count_s;

  serial_popcount #(
    .GROUP_W (GROUP_W),
    .COUNT_W (COUNT_W)
  ) u_popcount (
    .clk_i   (clock),
    .rst_ni  (resetN),
    .load_i  (pc_load_s),
    .shift_i (pc_shift_s),
    .data_i  (submatrixElements),
    .busy_o  (pc_busy_s),
    .last_o  (pc_last_s),
    .count_o (pc_count_s)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pc_load_s  = 1'b0;
    pc_shift_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (loaded) begin
          pc_load_s = 1'b1;
          state_d   = COUNT;
        end else begin
          state_d   = IDLE;
        end
      end
      COUNT: begin
        pc_shift_s = 1'b1;
        if (pc_last_s) begin
          state_d = WRITE;
        end else if (pc_busy_s) begin
          state_d = COUNT;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (addr_q == LAST_ADDR_C) begin
          state_d = DONE;
        end else begin
          addr_d  = addr_q + OUT_ADDR_W'(1);
          state_d = IDLE;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they are all register-driven.
    ready_d = (state_d == IDLE);
    wr_en_d = (state_d == WRITE);
    done_d  = (state_d == DONE);
    if (state_d == WRITE) begin
      wr_data_d = (pc_count_s >= THR_C);
    end else begin
      wr_data_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      ready_q   <= 1'b1;
      wr_en_q   <= 1'b0;
      wr_data_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ready_q   <= ready_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign readyToBeLoaded = ready_q;
  assign wrEn            = wr_en_q;
  assign wrAddress       = addr_q;
  assign wrData          = wr_data_q;
  assign done            = done_q;

`ifdef SUBMATRIX_DOWNSAMPLER_PROTOCOL_ERR_EN
  logic prot_err_q, prot_err_d;

  // Sticky: upstream presented a group while we were not accepting one.
  always_comb begin
    prot_err_d = prot_err_q | (loaded && (state_q != IDLE));
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      prot_err_q <= 1'b0;
    end else begin
      prot_err_q <= prot_err_d;
    end
  end

  assign protocolError = prot_err_q;
`endif

endmodule

// File: tb/tb_submatrix_downsampler.sv
// Self-checking bench for submatrix_downsampler (NUM_GROUPS=4) with a popcount/threshold reference model.
module tb_submatrix_downsampler;

  localparam int GW = 16;
  localparam int NG = 4;
  localparam int AW = 12;
  localparam int TH = 8;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          loaded = 1'b0;
  logic [GW-1:0] elems = '0;
  logic          ready, wr_en, wr_data, done_s;
  logic [AW-1:0] wr_addr;
`ifdef SUBMATRIX_DOWNSAMPLER_PROTOCOL_ERR_EN
  logic          prot_err;
`endif

  int tests = 0;
  int fails = 0;
  int exp_addr = 0;

  always #5 clock = ~clock;

  submatrix_downsampler #(
    .GROUP_W    (GW),
    .NUM_GROUPS (NG),
    .OUT_ADDR_W (AW),
    .THRESHOLD  (TH)
  ) dut (
    .clock             (clock),
    .resetN            (resetN),
    .loaded            (loaded),
    .submatrixElements (elems),
    .readyToBeLoaded   (ready),
    .wrEn              (wr_en),
    .wrAddress         (wr_addr),
    .wrData            (wr_data),
`ifdef SUBMATRIX_DOWNSAMPLER_PROTOCOL_ERR_EN
    .protocolError     (prot_err),
`endif
    .done              (done_s)
  );

  function automatic int popcnt(input logic [GW-1:0] v);
    int n = 0;
    for (int i = 0; i < GW; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    loaded = 1'b0;
    resetN = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetN = 1'b1;
    exp_addr = 0;
  endtask

  // Feeds one group and watches the following 18 cycles for exactly one write at cycle 17.
  task automatic run_group(input logic [GW-1:0] d, input string tag);
    int waits = 0;
    int hits = 0;
    int hit_k = 0;
    int hit_data = 0;
    int hit_addr = 0;
    int ready_bad = 0;
    int ready_after = 0;
    while (!ready && waits < 50) begin
      @(negedge clock);
      waits++;
    end
    check({tag, "_ready_in"}, 32'(ready), 1);
    loaded = 1'b1;
    elems  = d;
    @(negedge clock);
    loaded = 1'b0;
    elems  = GW'($urandom);
    for (int k = 1; k <= 18; k++) begin
      if (k > 1) @(negedge clock);
      if (wr_en) begin
        hits++;
        hit_k = k;
        hit_data = 32'(wr_data);
        hit_addr = 32'(wr_addr);
      end
      if (k <= 17 && ready) ready_bad++;
      if (k == 18) ready_after = 32'(ready);
    end
    check({tag, "_pulses"}, hits, 1);
    check({tag, "_latency"}, hit_k, 17);
    check({tag, "_data"}, hit_data, (popcnt(d) >= TH) ? 1 : 0);
    check({tag, "_addr"}, hit_addr, exp_addr);
    check({tag, "_busy_ready"}, ready_bad, 0);
    check({tag, "_ready_out"}, ready_after, (exp_addr == NG - 1) ? 0 : 1);
    check({tag, "_done"}, 32'(done_s), (exp_addr == NG - 1) ? 1 : 0);
    if (exp_addr < NG - 1) exp_addr++;
  endtask

  initial begin
    int cnt;
    int caps;
    int last_cap;
    int spacing_bad;
    int pulses;
    int cyc;
    logic [GW-1:0] cap_q[$];
    logic [GW-1:0] g;

    // Reset then idle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("idle_ready", 32'(ready), 1);
      check("idle_wren", 32'(wr_en), 0);
      check("idle_addr", 32'(wr_addr), 0);
      check("idle_done", 32'(done_s), 0);
      @(negedge clock);
    end
    check("idle_wrdata", 32'(wr_data), 0);
`ifdef SUBMATRIX_DOWNSAMPLER_PROTOCOL_ERR_EN
    check("perr_reset", 32'(prot_err), 0);
`endif

    // Directed threshold-edge groups through to completion
    run_group(16'hFF00, "g_ff00");
    run_group(16'h007F, "g_007f");
    run_group(16'hFFFF, "g_ffff");
    run_group(16'h0000, "g_0000");
    check("cmp_addr_hold", 32'(wr_addr), NG - 1);

    // A fifth group after completion is ignored
    cnt = 0;
    loaded = 1'b1;
    for (int i = 0; i < 20; i++) begin
      elems = GW'($urandom);
      @(negedge clock);
      if (wr_en) cnt++;
    end
    loaded = 1'b0;
    check("post_done_wren", cnt, 0);
    check("post_done_done", 32'(done_s), 1);
    check("post_done_ready", 32'(ready), 0);
    check("post_done_addr", 32'(wr_addr), NG - 1);

    // Random groups, plus boundary values around the threshold
    do_reset();
    g = 16'h0F0F;
    run_group(g, "r_eq_thr");
    g = 16'h0E0F;
    run_group(g, "r_thr_m1");
    run_group(GW'($urandom), "r_rand0");
    run_group(GW'($urandom), "r_rand1");

    // Reset in the fifth COUNT cycle aborts the group
    do_reset();
    loaded = 1'b1;
    elems  = 16'hFFFF;
    @(negedge clock);
    loaded = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clock);
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    check("abort_ready", 32'(ready), 1);
    check("abort_wren", 32'(wr_en), 0);
    check("abort_addr", 32'(wr_addr), 0);
    check("abort_done", 32'(done_s), 0);
`ifdef SUBMATRIX_DOWNSAMPLER_PROTOCOL_ERR_EN
    check("abort_perr", 32'(prot_err), 0);
`endif
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (wr_en) cnt++;
    end
    check("abort_no_write", cnt, 0);
    exp_addr = 0;
    run_group(GW'($urandom), "abort_next");

    // Reset and loaded at the same edge: reset wins, nothing captured
    loaded = 1'b1;
    elems  = 16'hFFFF;
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    loaded = 1'b0;
    exp_addr = 0;
    check("rst_vs_load_ready", 32'(ready), 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (wr_en) cnt++;
    end
    check("rst_vs_load_nowr", cnt, 0);

    // Backpressure: loaded held high with changing data
    do_reset();
    caps = 0;
    last_cap = -1;
    spacing_bad = 0;
    pulses = 0;
    loaded = 1'b1;
    for (cyc = 0; cyc < 110; cyc++) begin
      if (wr_en) begin
        check("bp_wr_addr", 32'(wr_addr), pulses);
        if (cap_q.size() > 0) begin
          g = cap_q.pop_front();
          check("bp_wr_data", 32'(wr_data), (popcnt(g) >= TH) ? 1 : 0);
        end else begin
          check("bp_unexpected_wr", 1, 0);
        end
        pulses++;
      end
      elems = GW'($urandom);
      if (ready) begin
        cap_q.push_back(elems);
        if (last_cap >= 0 && cyc - last_cap != 18) spacing_bad++;
        last_cap = cyc;
        caps++;
      end
      @(negedge clock);
    end
    loaded = 1'b0;
    check("bp_captures", caps, NG);
    check("bp_spacing", spacing_bad, 0);
    check("bp_pulses", pulses, NG);
    check("bp_queue_empty", cap_q.size(), 0);
    check("bp_done", 32'(done_s), 1);
`ifdef SUBMATRIX_DOWNSAMPLER_PROTOCOL_ERR_EN
    check("bp_perr", 32'(prot_err), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
